seq_magnitude_comparator: RTL and testbench

Multi-cycle unsigned magnitude comparator for WIDTH-bit operands.
- Compares a and b two bits per clock, MSB-first, using a 2-bit comparator slice; stops at the first unequal slice.
- Result is one-hot registered L/E/G with a single-cycle done pulse.
- Sits directly upstream of consumers of L/E/G comparator flags and extends the combinational 2-bit compare to wide words without a wide combinational path.

---
 rtl/cmp_pkg.sv | 23 ++
 rtl/cmp_slice_2bit.sv | 14 +
 rtl/seq_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: FSM states,
// one-hot {L,E,G} result codes and the default operand width.
package cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result codes laid out as {L, E, G}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // Slice index width; at least one bit even for a single-slice comparator.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cmp_slice_2bit.sv
// Combinational 2-bit unsigned compare; exactly one of lt/eq/gt is high.
module cmp_slice_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned comparator: walks the operands two bits per clock,
// MSB-first, and stops at the first unequal slice. WIDTH must be even.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  // Handshake: start is taken on any edge where busy is low (including the
  // done cycle); busy then stays high until the edge that raises done, and
  // L/E/G are valid from done onward until the next accepted start.

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] a_r, a_n;
  logic [WIDTH-1:0] b_r, b_n;
  logic [2:0]       res, res_n;
  logic             done_n;

  logic [1:0] slice_a, slice_b;
  logic       s_lt, s_eq, s_gt;

  assign slice_a = a_r[{idx, 1'b0} +: 2];
  assign slice_b = b_r[{idx, 1'b0} +: 2];

  cmp_slice_2bit u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= RES_NONE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      a_r   <= a_n;
      b_r   <= b_n;
      res   <= res_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_n     = a_r;
    b_n     = b_r;
    res_n   = res;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          idx_n   = IDX_TOP;
          res_n   = RES_NONE;
          state_n = RUN;
        end
      end
      RUN: begin
        if (s_lt) begin
          res_n   = RES_LT;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (s_gt) begin
          res_n   = RES_GT;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (s_eq && (idx == '0)) begin
          res_n   = RES_EQ;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign L    = res[2];
  assign E    = res[1];
  assign G    = res[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH = 8): expected
// results and done edges are queued at start and checked when done fires.
module tb_seq_magnitude_comparator;

  localparam int W     = 8;
  localparam int NS    = W / 2;
  localparam int EXP_W = 35;  // {L,E,G, expected done cycle[31:0]}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy, done, L, E, G;

  int unsigned  cyc;
  int           n_cmp;
  int           n_bad;
  int           last_k;
  logic [EXP_W-1:0] exp_q[$];

  seq_magnitude_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .L     (L),
    .E     (E),
    .G     (G)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    if (x < y)  return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Number of compare edges: 1-based position of first unequal slice from MSB.
  function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int s = NS - 1; s >= 0; s--)
      if (x[2*s +: 2] != y[2*s +: 2]) return NS - s;
    return NS;
  endfunction

  // Scoreboard monitor: checks every done against the queue head.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (busy) check_eq("leg_while_busy", {29'd0, L, E, G}, 32'd0);
    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("leg_result", {29'd0, L, E, G}, {29'd0, e[34:32]});
        check_eq("done_cycle", cyc, e[31:0]);
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    @(posedge clk);
    #1;
    last_k = ref_k(x, y);
    exp_q.push_back({ref_res(x, y), cyc + 32'(last_k)});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; checks busy length.
  task automatic wait_done();
    int n_busy;
    bit seen;
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n_busy++;
      @(negedge clk);
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    else check_eq("busy_cycles", 32'(n_busy), 32'(last_k));
  endtask

  task automatic idle_outputs(input string tag);
    check_eq(tag, {28'd0, busy, L, E, G}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // 1: reset state and quiet idle
    repeat (2) @(negedge clk);
    idle_outputs("reset_outputs");
    check_eq("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_outputs("idle_hold");
      check_eq("idle_done", {31'd0, done}, 32'd0);
    end

    // 2: MSB slice differs -> one-cycle latency
    launch(8'h00, 8'hFF);
    wait_done();
    @(negedge clk);
    check_eq("result_hold_L", {29'd0, L, E, G}, 32'h4);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);

    // 3: LSB slice differs, then equal operands
    launch(8'hA5, 8'hA4);
    wait_done();
    @(negedge clk);
    launch(8'h3C, 8'h3C);
    wait_done();
    @(negedge clk);

    // 4: start during RUN is ignored
    start = 1'b1;
    a_in  = 8'h40;
    b_in  = 8'h80;
    @(posedge clk);
    #1;
    last_k = ref_k(8'h40, 8'h80);
    exp_q.push_back({ref_res(8'h40, 8'h80), cyc + 32'(last_k)});
    a_in = 8'hFF;
    b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check_eq("ignored_start_queue", 32'(exp_q.size()), 32'd0);
    check_eq("ignored_start_idle", {31'd0, busy}, 32'd0);

    // 5: back-to-back, start accepted in the done cycle
    launch(8'h12, 8'h13);
    wait_done();
    launch(8'hF0, 8'h0F);
    check_eq("b2b_cleared", {28'd0, busy, L, E, G}, 32'h8);
    wait_done();
    @(negedge clk);

    // 6: reset mid-RUN aborts without done
    launch(8'h55, 8'h55);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    idle_outputs("abort_outputs");
    check_eq("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_eq("abort_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    launch(8'h01, 8'h02);
    wait_done();
    @(negedge clk);

    // random operands, with some forced near-equal pairs
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) :
           W'($urandom_range(0, 255));
      launch(ra, rb);
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
